// File: rtl/fft_w8_twiddle_stage_pkg.sv
// Shared FFT datapath definitions: sample width, W8 twiddle codes and
// the saturation/clamp helpers used around the sqrt(2)/2 multiplier.
package fft_w8_twiddle_stage_pkg;

    localparam int Q15_W = 16;

    typedef enum logic [1:0] {
        TW_ONE      = 2'd0,
        TW_HS2_NEG  = 2'd1,
        TW_NEGJ     = 2'd2,
        TW_HS2_NEG3 = 2'd3
    } tw_code_e;

    function automatic logic signed [Q15_W-1:0] sat17to16(input logic signed [Q15_W:0] x);
        if (x > 17'sd32767) begin
            return 16'sd32767;
        end else if (x < -17'sd32767) begin
            return -16'sd32767;
        end else begin
            return x[Q15_W-1:0];
        end
    endfunction

    // Keeps every operand symmetric so negation and |x| cannot overflow.
    function automatic logic signed [Q15_W-1:0] clamp_q15(input logic signed [Q15_W-1:0] x);
        return (x == 16'sh8000) ? 16'sh8001 : x;
    endfunction

endpackage

// File: rtl/fft_w8_twiddle_stage_hs2mul.sv
// Constant multiplier by sqrt(2)/2 (2896/4096), sign-magnitude so the
// result truncates toward zero. Input is expected to be clamped to +/-32767.
module fft_w8_twiddle_stage_hs2mul
    import fft_w8_twiddle_stage_pkg::*;
(
    input  logic signed [Q15_W-1:0] x,
    output logic signed [Q15_W-1:0] y
);

    logic [14:0] mag;
    logic [26:0] prod;
    logic [14:0] hmag;

    always_comb begin
        mag  = x[15] ? 15'(-x) : x[14:0];
        // 2896 = 2^11 + 2^9 + 2^8 + 2^6 + 2^4
        prod = (27'(mag) << 11) + (27'(mag) << 9) + (27'(mag) << 8)
             + (27'(mag) << 6) + (27'(mag) << 4);
        hmag = prod[26:12];
        y    = x[15] ? 16'(-{1'b0, hmag}) : {1'b0, hmag};
    end

endmodule

// File: rtl/fft_w8_twiddle_stage.sv
// Inter-stage W8 twiddle rotator: two-register valid/ready pipeline that
// rotates each sample by the twiddle picked from its index in the frame.
module fft_w8_twiddle_stage
    import fft_w8_twiddle_stage_pkg::*;
#(
    parameter int N_POINTS = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sop,
    input  logic signed [Q15_W-1:0] in_re,
    input  logic signed [Q15_W-1:0] in_im,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sop,
    output logic                    out_last,
    output logic signed [Q15_W-1:0] out_re,
    output logic signed [Q15_W-1:0] out_im,
    output logic                    sop_err
);

    localparam int CW = $clog2(N_POINTS);

    logic [CW-1:0]           cnt;
    logic [CW-1:0]           idx;
    logic                    s2_load;
    logic                    hs_in;
    tw_code_e                k_sel;
    logic signed [Q15_W-1:0] ca, cb;
    logic signed [Q15_W:0]   sum_ab, dif_ba, neg_sum;
    logic signed [Q15_W-1:0] pre_re, pre_im;

    logic                    s1_valid, s1_sop, s1_last;
    tw_code_e                s1_k;
    logic signed [Q15_W-1:0] s1_re, s1_im;
    logic signed [Q15_W-1:0] h_re, h_im;

    assign s2_load  = !out_valid | out_ready;
    assign in_ready = !s1_valid | s2_load;
    assign hs_in    = in_valid & in_ready;
    assign idx      = in_sop ? '0 : cnt;

    always_comb begin
        k_sel   = idx[2] ? tw_code_e'(idx[1:0]) : TW_ONE;
        ca      = clamp_q15(in_re);
        cb      = clamp_q15(in_im);
        sum_ab  = {ca[15], ca} + {cb[15], cb};
        dif_ba  = {cb[15], cb} - {ca[15], ca};
        neg_sum = -{ca[15], ca} - {cb[15], cb};
        pre_re  = in_re;
        pre_im  = in_im;
        case (k_sel)
            TW_HS2_NEG: begin
                pre_re = sat17to16(sum_ab);
                pre_im = sat17to16(dif_ba);
            end
            TW_NEGJ: begin
                pre_re = in_im;
                pre_im = -ca;
            end
            TW_HS2_NEG3: begin
                pre_re = sat17to16(dif_ba);
                pre_im = sat17to16(neg_sum);
            end
            default: begin
                pre_re = in_re;
                pre_im = in_im;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            sop_err  <= 1'b0;
            s1_valid <= 1'b0;
            s1_sop   <= 1'b0;
            s1_last  <= 1'b0;
            s1_k     <= TW_ONE;
            s1_re    <= '0;
            s1_im    <= '0;
        end else begin
            if (hs_in) begin
                cnt <= idx + 1'b1;
                if (in_sop && cnt != '0) begin
                    sop_err <= 1'b1;
                end
            end
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_sop  <= in_sop;
                    s1_last <= (idx == CW'(N_POINTS - 1));
                    s1_k    <= k_sel;
                    s1_re   <= pre_re;
                    s1_im   <= pre_im;
                end
            end
        end
    end

    fft_w8_twiddle_stage_hs2mul u_mul_re (.x(s1_re), .y(h_re));
    fft_w8_twiddle_stage_hs2mul u_mul_im (.x(s1_im), .y(h_im));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_last  <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sop  <= s1_sop;
                out_last <= s1_last;
                if (s1_k == TW_HS2_NEG || s1_k == TW_HS2_NEG3) begin
                    out_re <= h_re;
                    out_im <= h_im;
                end else begin
                    out_re <= s1_re;
                    out_im <= s1_im;
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_w8_twiddle_stage.sv
// Scoreboard bench for the W8 twiddle rotator: reference model, directed
// corner values, random backpressure, frame-sync error and mid-frame reset.
module tb_fft_w8_twiddle_stage;

    localparam int N = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_sop = 1'b0;
    logic signed [15:0] in_re = '0;
    logic signed [15:0] in_im = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              out_sop, out_last;
    logic signed [15:0] out_re, out_im;
    logic              sop_err;

    always #5 clk = ~clk;

    fft_w8_twiddle_stage #(.N_POINTS(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop),
        .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sop(out_sop), .out_last(out_last),
        .out_re(out_re), .out_im(out_im),
        .sop_err(sop_err)
    );

    typedef struct {
        int re;
        int im;
        bit sop;
        bit last;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   model_n = 0;
    int   cyc = 0;
    bit   ov_en = 0;
    int   ov_re = 0, ov_im = 0;
    bit   bp_mode = 0;
    logic ready_force = 1'b1;
    bit   held = 0;
    logic [15:0] h_re, h_im;
    logic h_sop, h_last;
    exp_t mon_e;
    int   mon_idx;

    task automatic check(string tag, int obs, int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat(int x);
        if (x > 32767) return 32767;
        if (x < -32767) return -32767;
        return x;
    endfunction

    function automatic int clampv(int x);
        return (x == -32768) ? -32767 : x;
    endfunction

    function automatic int hmul(int x);
        int m;
        int r;
        m = (x < 0) ? -x : x;
        r = (m * 2896) / 4096;
        return (x < 0) ? -r : r;
    endfunction

    function automatic exp_t model(int a, int b, bit sop, int idx);
        exp_t e;
        int ca, cb, m, k;
        ca = clampv(a);
        cb = clampv(b);
        m  = idx % 8;
        k  = (m >= 4) ? m - 4 : 0;
        case (k)
            1: begin e.re = hmul(sat(ca + cb)); e.im = hmul(sat(cb - ca)); end
            2: begin e.re = b;                  e.im = -ca;               end
            3: begin e.re = hmul(sat(cb - ca)); e.im = hmul(sat(-ca - cb)); end
            default: begin e.re = a; e.im = b; end
        endcase
        e.sop  = sop;
        e.last = (idx == N - 1);
        e.cyc  = 0;
        return e;
    endfunction

    function automatic int rnd16();
        case ($urandom_range(0, 9))
            0: return -32768;
            1: return 32767;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        out_ready = bp_mode ? ($urandom_range(0, 99) < 30) : ready_force;
    end

    // Monitor: stall stability, output pop/compare, input push.
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 0;
            sb.delete();
            model_n = 0;
        end else begin
            if (held) begin
                check("stall_valid", int'(out_valid), 1);
                check("stall_re", int'(out_re), int'($signed(h_re)));
                check("stall_im", int'(out_im), int'($signed(h_im)));
                check("stall_flags", int'({out_sop, out_last}), int'({h_sop, h_last}));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", sb.size(), 1);
                end else begin
                    mon_e = sb.pop_front();
                    check("out_re", int'(out_re), mon_e.re);
                    check("out_im", int'(out_im), mon_e.im);
                    check("out_sop", int'(out_sop), int'(mon_e.sop));
                    check("out_last", int'(out_last), int'(mon_e.last));
                    if (mon_e.sop && !bp_mode)
                        check("latency", cyc - mon_e.cyc, 2);
                end
            end
            held   = out_valid && !out_ready;
            h_re   = out_re;
            h_im   = out_im;
            h_sop  = out_sop;
            h_last = out_last;
            if (in_valid && in_ready) begin
                mon_idx = in_sop ? 0 : model_n;
                model_n = (mon_idx + 1) % N;
                mon_e = model(int'(in_re), int'(in_im), in_sop, mon_idx);
                if (ov_en) begin
                    mon_e.re = ov_re;
                    mon_e.im = ov_im;
                end
                mon_e.cyc = cyc;
                sb.push_back(mon_e);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the handshake.
    task automatic send(int a, int b, bit sop, bit ov = 0, int er = 0, int ei = 0);
        int budget;
        budget   = 0;
        in_valid = 1'b1;
        in_re    = 16'(a);
        in_im    = 16'(b);
        in_sop   = sop;
        ov_en    = ov;
        ov_re    = er;
        ov_im    = ei;
        do begin
            @(negedge clk);
            budget++;
        end while (!in_ready && budget < 1000);
        if (!in_ready) check("in_ready_timeout", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        ov_en    = 0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((sb.size() != 0 || out_valid) && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        check("drain_left", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_re", int'(out_re), 0);
        check("rst_out_im", int'(out_im), 0);
        check("rst_out_flags", int'({out_sop, out_last}), 0);
        check("rst_sop_err", int'(sop_err), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_idle", int'(in_ready), 1);

        // Frame 1: pass-through, k=1/2/3 corner values, last flag
        for (int i = 0; i < N; i++) begin
            case (i)
                0: send(1000, -2000, 1, 1, 1000, -2000);
                5: send(16384, 0, 0, 1, 11584, -11584);
                6: send(-32768, 0, 0, 1, 0, 32767);
                7: send(1000, 3000, 0, 1, 1414, -2828);
                default: send(rnd16(), rnd16(), 0);
            endcase
        end
        drain();

        // Frame 2: saturation of a+b ahead of the multiplier
        for (int i = 0; i < N; i++) begin
            if (i == 5) send(32767, 32767, 0, 1, 23167, 0);
            else        send(rnd16(), rnd16(), i == 0);
        end
        drain();

        // Three frames under random backpressure
        bp_mode = 1;
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < N; i++)
                send(rnd16(), rnd16(), i == 0);
        drain();
        bp_mode = 0;

        // Frame sync error: sop at index 20
        for (int i = 0; i < 20; i++) send(rnd16(), rnd16(), i == 0);
        drain();
        check("sop_err_clear", int'(sop_err), 0);
        send(-12345, 23456, 1, 1, -12345, 23456);
        for (int i = 0; i < 10; i++) send(rnd16(), rnd16(), 0);
        drain();
        check("sop_err_set", int'(sop_err), 1);

        // Mid-frame reset with both stages full
        ready_force = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send(111, 222, 0);
        send(333, 444, 0);
        check("full_out_valid", int'(out_valid), 1);
        check("full_in_ready", int'(in_ready), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_out_re", int'(out_re), 0);
        check("arst_out_im", int'(out_im), 0);
        check("arst_sop_err", int'(sop_err), 0);
        ready_force = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(100, 200, 0, 1, 100, 200);
        for (int i = 1; i < 10; i++) send(rnd16(), rnd16(), 0);
        drain();
        check("post_rst_sop_err", int'(sop_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
